uart_spi_burst_bridge: RTL
==========================

Name: uart_spi_burst_bridge

Overview:
Framed command bridge between the UART byte stream and the SPI register master. Parses SOF/CMD/ADDR/DATA frames from the UART receiver and issues single or burst SPI register reads and writes with address auto-increment. Serialises read data and ACK/NAK status back through the UART transmitter. Replaces the single-word state controller inside the UART data controller and adds burst, timeouts and error reporting.

Parameters:
SPI_ADDR_WIDTH, 6, SPI register address width (1..16); ADDR_BYTES = ceil(SPI_ADDR_WIDTH/8).
SPI_DATA_WIDTH, 20, SPI register data width (1..32); DATA_BYTES = ceil(SPI_DATA_WIDTH/8).
MAX_BURST, 16, maximum words per frame (1..128).
SOF_BYTE, 8'hA5, frame start byte.
ACK_BYTE, 8'h4B, success status byte.
NAK_BYTE, 8'h4E, failure status byte.
RX_TIMEOUT, 66000, maximum i_clk_sys cycles between bytes inside a frame.
SPI_TIMEOUT, 4096, maximum cycles from o_spi_start to i_spi_data_valid.

Ports:
i_clk_sys  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_uart_data  in  8  received UART byte
i_rx_done  in  1  one-cycle strobe, i_uart_data valid
i_uart_idle  in  1  UART transmitter idle
o_data_tx  out  8  byte to transmit
o_data_valid  out  1  one-cycle transmit strobe
i_spi_data_valid  in  1  SPI transaction complete; read data valid
i_spi_read_data  in  SPI_DATA_WIDTH  SPI read data
o_spi_start  out  1  one-cycle SPI start strobe
o_spi_rw  out  1  1 = read, 0 = write
o_spi_addr  out  SPI_ADDR_WIDTH  SPI register address
o_spi_data  out  SPI_DATA_WIDTH  SPI write data
o_busy  out  1  high when the FSM is not in IDLE
o_ld_debug  out  7  {err_sticky, 2'b0, state[3:0]}

Behaviour:
- Reset: all outputs are 0; FSM = IDLE; the burst counter, address and timers are cleared; the sticky error flag is cleared. Reset mid-frame or mid-SPI abandons the operation; no further strobes are issued.
- Frame format: SOF, CMD, ADDR (ADDR_BYTES), then for writes len×DATA_BYTES data bytes. All multi-byte fields are MSB first. CMD[7] is rw; CMD[6:0] is len-1.
- Unused upper address and data bits are ignored on receive and sent as zero on transmit.
- FSM states: IDLE, CMD, ADDR, WDATA, SPI_GO, SPI_WAIT, RD_TX, TX_WAIT, STATUS.
- IDLE: bytes other than SOF_BYTE are dropped silently. SOF_BYTE moves the FSM to CMD.
- CMD: if len > MAX_BURST, go to STATUS with NAK; otherwise latch rw and len, then go to ADDR.
- ADDR: after the last address byte, go to WDATA for writes or SPI_GO for reads.
- WDATA: after the DATA_BYTES-th byte of a word, go to SPI_GO.
- SPI_GO:
  - The cycle after entry, o_spi_start pulses for 1 cycle.
  - o_spi_addr, o_spi_rw and o_spi_data are valid that cycle and are held until i_spi_data_valid.
  - The FSM then enters SPI_WAIT.
- SPI_WAIT: on i_spi_data_valid, a read captures i_spi_read_data and goes to RD_TX.
  - A write with more words increments the address and returns to WDATA.
  - The last write word goes to STATUS with ACK.
- Address increment wraps modulo 2^SPI_ADDR_WIDTH.
- RD_TX: sends DATA_BYTES bytes MSB first.
  - After the last byte, a read with more words increments the address and returns to SPI_GO.
  - After the last byte of the last word, go to STATUS with ACK.
- Transmit handshake:
  - o_data_valid pulses only while i_uart_idle = 1.
  - The FSM then waits in TX_WAIT until i_uart_idle has been seen low and then high before the next byte.
- STATUS: sends one ACK/NAK byte through the transmit handshake, then returns to IDLE.
- RX timeout: the inter-byte counter runs in CMD, ADDR and WDATA. It is reset on each i_rx_done. Reaching RX_TIMEOUT gives NAK, sets the sticky error flag and goes to STATUS.
- SPI timeout: the counter starts at o_spi_start. Reaching SPI_TIMEOUT gives NAK, sets the sticky error flag and goes to STATUS; no read data is sent.
- Write overrun: a single-byte holding register accepts one i_rx_done during SPI_SPI_WAIT/SPI_GO of a write. A second byte before the register is consumed gives NAK, sets the sticky error flag and goes to STATUS.
- Bytes received in RD_TX, TX_WAIT or STATUS are dropped.
- Simultaneous events: i_rx_done and a timeout expiry in the same cycle resolve in favour of the byte.
- The sticky error flag clears only on reset.

Test Plan:
1. Write: A5 00 12 0A BC DE -> single o_spi_start with rw=0, addr=6'h12, data=20'hABCDE. After valid, tx is 4B.
2. Read burst: A5 82 3E; SPI returns 20'h11111, 20'h22222, 20'h33333 -> addrs 3E, 3F, 00 (wrap); tx is 01 11 11 02 22 22 03 33 33 4B.
3. Bad length: 55 00 A5 FF with MAX_BURST=16 -> junk ignored, no o_spi_start, tx is 4E, o_ld_debug[6]=1.
4. Timeouts: A5 01 then silence for RX_TIMEOUT cycles -> tx 4E, FSM back to IDLE. Separately, a read with i_spi_data_valid held low -> 4E after SPI_TIMEOUT cycles.
5. Burst write with a slow SPI: second byte arrives during SPI_WAIT -> held and used; a third early byte -> 4E.
6. Reset mid-operation: i_rst asserted during RD_TX of the second word -> all outputs 0 next edge, o_busy=0, and a new frame then completes normally.

Source files
------------

// File: rtl/uart_spi_burst_bridge_if.sv
// rtl/uart_spi_burst_bridge_if.sv - UART byte stream and SPI register master signals of the burst bridge
// master: bridge side (receives UART bytes / SPI completions, drives TX bytes and SPI requests)
// slave : environment side (UART receiver/transmitter and SPI master)
interface uart_spi_burst_bridge_if #(
    parameter int SPI_ADDR_WIDTH = 6,
    parameter int SPI_DATA_WIDTH = 20
);
    logic [7:0]                i_uart_data;
    logic                      i_rx_done;
    logic                      i_uart_idle;
    logic [7:0]                o_data_tx;
    logic                      o_data_valid;
    logic                      i_spi_data_valid;
    logic [SPI_DATA_WIDTH-1:0] i_spi_read_data;
    logic                      o_spi_start;
    logic                      o_spi_rw;
    logic [SPI_ADDR_WIDTH-1:0] o_spi_addr;
    logic [SPI_DATA_WIDTH-1:0] o_spi_data;

    modport master (
        input  i_uart_data, i_rx_done, i_uart_idle, i_spi_data_valid, i_spi_read_data,
        output o_data_tx, o_data_valid, o_spi_start, o_spi_rw, o_spi_addr, o_spi_data
    );

    modport slave (
        output i_uart_data, i_rx_done, i_uart_idle, i_spi_data_valid, i_spi_read_data,
        input  o_data_tx, o_data_valid, o_spi_start, o_spi_rw, o_spi_addr, o_spi_data
    );
endinterface

// File: rtl/uart_spi_burst_bridge.sv
// rtl/uart_spi_burst_bridge.sv - framed UART command bridge issuing single/burst SPI register accesses
// Ports: i_clk_sys, i_rst (sync, active-high); bus (UART rx/tx bytes and SPI request/completion);
//        o_busy (FSM not idle); o_ld_debug = {err_sticky, 2'b0, state[3:0]}
module uart_spi_burst_bridge #(
    parameter int         SPI_ADDR_WIDTH = 6,
    parameter int         SPI_DATA_WIDTH = 20,
    parameter int         MAX_BURST      = 16,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] NAK_BYTE       = 8'h4E,
    parameter int         RX_TIMEOUT     = 66000,
    parameter int         SPI_TIMEOUT    = 4096
) (
    input  logic                   i_clk_sys,
    input  logic                   i_rst,
    uart_spi_burst_bridge_if.master bus,
    output logic                   o_busy,
    output logic [6:0]             o_ld_debug
);
    localparam int ADDR_BYTES = (SPI_ADDR_WIDTH + 7) / 8;
    localparam int DATA_BYTES = (SPI_DATA_WIDTH + 7) / 8;
    localparam int RX_CW      = $clog2(RX_TIMEOUT + 1);
    localparam int SPI_CW     = $clog2(SPI_TIMEOUT + 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_CMD = 4'd1, ST_ADDR = 4'd2, ST_WDATA = 4'd3, ST_SPI_GO = 4'd4,
        ST_SPI_WAIT = 4'd5, ST_RD_TX = 4'd6, ST_TX_WAIT = 4'd7, ST_STATUS = 4'd8
    } state_t;

    state_t                    state_q, state_d;
    logic                      err_q, err_d, rw_q, rw_d;
    logic [6:0]                words_q, words_d;       // words remaining after the current one
    logic [2:0]                byte_cnt_q, byte_cnt_d;
    logic [SPI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SPI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_BYTES*8-1:0]   rd_sh_q, rd_sh_d;
    logic [7:0]                hold_q, hold_d, status_q, status_d, tx_data_q, tx_data_d;
    logic                      hold_vld_q, hold_vld_d, tx_valid_q, tx_valid_d, start_q, start_d;
    logic                      seen_low_q, seen_low_d, tx_status_q, tx_status_d;
    logic [RX_CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [SPI_CW-1:0]         spi_cnt_q, spi_cnt_d;
    logic                      rx_active, byte_vld, fail, write_hold;
    logic [7:0]                byte_val;

    always_comb begin
        state_d     = state_q;     err_d       = err_q;       rw_d       = rw_q;
        words_d     = words_q;     byte_cnt_d  = byte_cnt_q;  addr_d     = addr_q;
        wdata_d     = wdata_q;     rd_sh_d     = rd_sh_q;     hold_d     = hold_q;
        hold_vld_d  = hold_vld_q;  status_d    = status_q;    tx_data_d  = tx_data_q;
        tx_valid_d  = 1'b0;        start_d     = 1'b0;        seen_low_d = seen_low_q;
        tx_status_d = tx_status_q; spi_cnt_d   = spi_cnt_q;   fail       = 1'b0;

        rx_active  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_WDATA);
        write_hold = !rw_q && ((state_q == ST_SPI_GO) || (state_q == ST_SPI_WAIT));
        // A byte parked during the previous SPI write is consumed before new UART bytes.
        if (state_q == ST_WDATA && hold_vld_q) begin
            byte_vld = 1'b1;
            byte_val = hold_q;
        end else begin
            byte_vld = bus.i_rx_done;
            byte_val = bus.i_uart_data;
        end

        // Inter-byte timer; a byte arriving in the expiry cycle wins.
        rx_cnt_d = (!rx_active || byte_vld) ? '0 : rx_cnt_q + RX_CW'(1);
        if (rx_active && !byte_vld && rx_cnt_q == RX_CW'(RX_TIMEOUT - 1)) fail = 1'b1;

        if (write_hold && bus.i_rx_done) begin
            if (hold_vld_q) begin
                fail = 1'b1;
            end else begin
                hold_d     = bus.i_uart_data;
                hold_vld_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                hold_vld_d = 1'b0;
                if (bus.i_rx_done && bus.i_uart_data == SOF_BYTE) state_d = ST_CMD;
            end
            ST_CMD: if (byte_vld) begin
                if ({1'b0, byte_val[6:0]} >= 8'(MAX_BURST)) begin
                    fail = 1'b1;
                end else begin
                    rw_d       = byte_val[7];
                    words_d    = byte_val[6:0];
                    byte_cnt_d = 3'd0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: if (byte_vld) begin
                addr_d = SPI_ADDR_WIDTH'({addr_q, byte_val});
                if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
                    byte_cnt_d = 3'd0;
                    state_d    = rw_q ? ST_SPI_GO : ST_WDATA;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end
            ST_WDATA: if (byte_vld) begin
                if (hold_vld_q) begin
                    hold_d     = bus.i_uart_data;
                    hold_vld_d = bus.i_rx_done;
                end
                wdata_d = SPI_DATA_WIDTH'({wdata_q, byte_val});
                if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                    byte_cnt_d = 3'd0;
                    state_d    = ST_SPI_GO;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end
            ST_SPI_GO: begin
                start_d   = 1'b1;
                spi_cnt_d = '0;
                state_d   = ST_SPI_WAIT;
            end
            ST_SPI_WAIT: begin
                if (bus.i_spi_data_valid) begin
                    if (rw_q) begin
                        rd_sh_d    = (DATA_BYTES*8)'(bus.i_spi_read_data);
                        byte_cnt_d = 3'd0;
                        state_d    = ST_RD_TX;
                    end else if (words_q != 7'd0) begin
                        words_d = words_q - 7'd1;
                        addr_d  = addr_q + SPI_ADDR_WIDTH'(1);
                        state_d = ST_WDATA;
                    end else begin
                        status_d = ACK_BYTE;
                        state_d  = ST_STATUS;
                    end
                end else if (spi_cnt_q == SPI_CW'(SPI_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    spi_cnt_d = spi_cnt_q + SPI_CW'(1);
                end
            end
            ST_RD_TX: if (bus.i_uart_idle) begin
                tx_valid_d  = 1'b1;
                tx_data_d   = rd_sh_q[DATA_BYTES*8-1 -: 8];
                rd_sh_d     = rd_sh_q << 8;
                tx_status_d = 1'b0;
                seen_low_d  = 1'b0;
                state_d     = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                // The transmitter must be seen busy and then idle again before moving on.
                if (!bus.i_uart_idle) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (tx_status_q) begin
                        state_d = ST_IDLE;
                    end else if (byte_cnt_q != 3'(DATA_BYTES - 1)) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = ST_RD_TX;
                    end else if (words_q != 7'd0) begin
                        words_d    = words_q - 7'd1;
                        addr_d     = addr_q + SPI_ADDR_WIDTH'(1);
                        byte_cnt_d = 3'd0;
                        state_d    = ST_SPI_GO;
                    end else begin
                        status_d = ACK_BYTE;
                        state_d  = ST_STATUS;
                    end
                end
            end
            ST_STATUS: if (bus.i_uart_idle) begin
                tx_valid_d  = 1'b1;
                tx_data_d   = status_q;
                tx_status_d = 1'b1;
                seen_low_d  = 1'b0;
                state_d     = ST_TX_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            state_d  = ST_STATUS;
            status_d = NAK_BYTE;
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q    <= ST_IDLE; err_q      <= 1'b0; rw_q        <= 1'b0; words_q    <= '0;
            byte_cnt_q <= '0;      addr_q     <= '0;   wdata_q     <= '0;   rd_sh_q    <= '0;
            hold_q     <= '0;      hold_vld_q <= 1'b0; status_q    <= '0;   tx_data_q  <= '0;
            tx_valid_q <= 1'b0;    start_q    <= 1'b0; seen_low_q  <= 1'b0; tx_status_q <= 1'b0;
            rx_cnt_q   <= '0;      spi_cnt_q  <= '0;
        end else begin
            state_q    <= state_d; err_q      <= err_d;      rw_q        <= rw_d;    words_q    <= words_d;
            byte_cnt_q <= byte_cnt_d; addr_q  <= addr_d;     wdata_q     <= wdata_d; rd_sh_q    <= rd_sh_d;
            hold_q     <= hold_d;  hold_vld_q <= hold_vld_d; status_q    <= status_d; tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d; start_q <= start_d;    seen_low_q  <= seen_low_d;
            tx_status_q <= tx_status_d; rx_cnt_q <= rx_cnt_d; spi_cnt_q  <= spi_cnt_d;
        end
    end

    assign bus.o_data_tx    = tx_data_q;
    assign bus.o_data_valid = tx_valid_q;
    assign bus.o_spi_start  = start_q;
    assign bus.o_spi_rw     = rw_q;
    assign bus.o_spi_addr   = addr_q;
    assign bus.o_spi_data   = wdata_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_ld_debug       = {err_q, 2'b00, state_q};
endmodule
